// File: rtl/router_port_tx_pkg.sv
// Shared types and constants for the router port transmitter and its bench.
package router_pkg;

  localparam int ADDR_BITS          = 4;
  localparam int DEFAULT_PAD_CYCLES = 5;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_ADDR,
    TX_PAD,
    TX_DATA,
    TX_GAP,
    TX_EOP
  } tx_state_e;

  typedef struct {
    logic [ADDR_BITS-1:0] addr;
    logic [7:0]           bytes[];
  } router_pkt_t;

endpackage

// File: rtl/router_port_tx_if.sv
// Upstream valid/ready byte stream feeding one router port transmitter.
interface router_port_tx_if;
  import router_pkg::*;

  logic                 s_valid;
  logic                 s_ready;
  logic [ADDR_BITS-1:0] s_addr;
  logic [7:0]           s_data;
  logic                 s_last;

  modport master (output s_valid, output s_addr, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_addr, input s_data, input s_last, output s_ready);

endinterface

// File: rtl/router_port_tx_shift.sv
// 8-bit LSB-first load/shift register with bit index and last-bit flag.
module router_tx_shift (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       shift_i,
  output logic       bit_o,
  output logic       at_last_bit_o
);

  logic [7:0] shift_q;
  logic [2:0] idx_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (load_i) begin
      shift_q <= data_i;
      idx_q   <= '0;
    end else if (shift_i) begin
      shift_q <= {1'b0, shift_q[7:1]};
      idx_q   <= idx_q + 3'd1;
    end
  end

  assign bit_o         = shift_q[0];
  assign at_last_bit_o = (idx_q == 3'd7);

endmodule

// File: rtl/router_port_tx.sv
// Serializes a valid/ready byte stream onto one router port (din/frame_n/valid_n).
// Define ROUTER_TX_STATS_EN to add pkt_cnt/byte_cnt statistics outputs.
module router_port_tx
  import router_pkg::*;
#(
  parameter int PAD_CYCLES = DEFAULT_PAD_CYCLES
) (
  input  logic             clock,
  input  logic             reset_n,
  router_port_tx_if.slave  up,
  output logic             din,
  output logic             frame_n,
  output logic             valid_n,
  output logic             tx_busy
`ifdef ROUTER_TX_STATS_EN
  ,
  output logic [15:0]      pkt_cnt,
  output logic [31:0]      byte_cnt
`endif
);

  localparam int CNT_MAX = (PAD_CYCLES > ADDR_BITS) ? PAD_CYCLES : ADDR_BITS;
  localparam int CNT_W   = $clog2(CNT_MAX);

  tx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 curLast_q, curLast_d;
  logic                 holdFull_q, holdFull_d;
  logic [7:0]           holdData_q, holdData_d;
  logic                 holdLast_q, holdLast_d;
  logic [ADDR_BITS-1:0] holdAddr_q, holdAddr_d;
  logic                 startNext_q, startNext_d;
  logic                 din_q, din_d;
  logic                 frameN_q, frameN_d;
  logic                 validN_q, validN_d;

  logic accept;
  logic load;
  logic shiftEn;
  logic shiftBit;
  logic atLastBit;

  // The address travels with the first byte so a queued next packet cannot disturb the one in flight.
  assign accept      = up.s_valid && !holdFull_q;
  assign holdFull_d  = accept || (holdFull_q && !load);
  assign holdData_d  = accept ? up.s_data : holdData_q;
  assign holdLast_d  = accept ? up.s_last : holdLast_q;
  assign holdAddr_d  = (accept && startNext_q) ? up.s_addr : holdAddr_q;
  assign startNext_d = accept ? up.s_last : startNext_q;

  router_tx_shift u_shift (
    .clock         (clock),
    .reset_n       (reset_n),
    .load_i        (load),
    .data_i        (holdData_q),
    .shift_i       (shiftEn),
    .bit_o         (shiftBit),
    .at_last_bit_o (atLastBit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    curLast_d = curLast_q;
    load      = 1'b0;
    shiftEn   = 1'b0;
    din_d     = 1'b0;
    frameN_d  = 1'b1;
    validN_d  = 1'b1;
    case (state_q)
      TX_IDLE: begin
        if (holdFull_q) begin
          load    = 1'b1;
          addr_d  = holdAddr_q;
          cnt_d   = '0;
          state_d = TX_ADDR;
        end
      end
      TX_ADDR: begin
        din_d    = addr_q[cnt_q[1:0]];
        frameN_d = 1'b0;
        validN_d = 1'b0;
        if (cnt_q == CNT_W'(ADDR_BITS - 1)) begin
          cnt_d   = '0;
          state_d = TX_PAD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TX_PAD: begin
        din_d    = 1'b1;
        frameN_d = 1'b0;
        if (cnt_q == CNT_W'(PAD_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = TX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TX_DATA: begin
        din_d    = shiftBit;
        frameN_d = curLast_q && atLastBit;
        validN_d = 1'b0;
        if (!atLastBit) begin
          shiftEn = 1'b1;
        end else if (curLast_q) begin
          state_d = TX_EOP;
        end else if (holdFull_q) begin
          load = 1'b1;
        end else begin
          state_d = TX_GAP;
        end
      end
      TX_GAP: begin
        din_d    = 1'b1;
        frameN_d = 1'b0;
        if (holdFull_q) begin
          load    = 1'b1;
          state_d = TX_DATA;
        end
      end
      TX_EOP: begin
        state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
    if (load) begin
      curLast_d = holdLast_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= TX_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      curLast_q   <= 1'b0;
      holdFull_q  <= 1'b0;
      holdData_q  <= '0;
      holdLast_q  <= 1'b0;
      holdAddr_q  <= '0;
      startNext_q <= 1'b1;
      din_q       <= 1'b0;
      frameN_q    <= 1'b1;
      validN_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      curLast_q   <= curLast_d;
      holdFull_q  <= holdFull_d;
      holdData_q  <= holdData_d;
      holdLast_q  <= holdLast_d;
      holdAddr_q  <= holdAddr_d;
      startNext_q <= startNext_d;
      din_q       <= din_d;
      frameN_q    <= frameN_d;
      validN_q    <= validN_d;
    end
  end

  assign up.s_ready = !holdFull_q;
  assign tx_busy    = (state_q != TX_IDLE) || holdFull_q;
  assign din        = din_q;
  assign frame_n    = frameN_q;
  assign valid_n    = validN_q;

`ifdef ROUTER_TX_STATS_EN
  logic [15:0] pktCnt_q;
  logic [31:0] byteCnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pktCnt_q  <= '0;
      byteCnt_q <= '0;
    end else begin
      if (state_q == TX_EOP) pktCnt_q <= pktCnt_q + 16'd1;
      if (load) byteCnt_q <= byteCnt_q + 32'd1;
    end
  end

  assign pkt_cnt  = pktCnt_q;
  assign byte_cnt = byteCnt_q;
`endif

endmodule

// File: tb/tb_router_port_tx.sv
// Self-checking bench for router_port_tx: vector table plus scoreboard-decoded serial output.
`timescale 1ns/1ps
module tb_router_port_tx;
  import router_pkg::*;

  localparam int PAD = DEFAULT_PAD_CYCLES;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic din, frame_n, valid_n, tx_busy;
`ifdef ROUTER_TX_STATS_EN
  logic [15:0] pkt_cnt;
  logic [31:0] byte_cnt;
`endif

  router_port_tx_if txIf ();

  router_port_tx #(.PAD_CYCLES(PAD)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .up      (txIf),
    .din     (din),
    .frame_n (frame_n),
    .valid_n (valid_n),
    .tx_busy (tx_busy)
`ifdef ROUTER_TX_STATS_EN
    ,
    .pkt_cnt  (pkt_cnt),
    .byte_cnt (byte_cnt)
`endif
  );

  always #5 clock = ~clock;

  int vectorCount = 0;
  int miscompares = 0;
  int cyc = 0;
  int acceptCyc = 0;

  always @(posedge clock) cyc++;

  logic [3:0] expAddrQ[$];
  int         expLenQ[$];
  logic [7:0] expByteQ[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Serial-line monitor: decodes each frame and settles it against the scoreboard.
  int          mcyc = 0;
  logic        inFrame = 1'b0;
  logic        eopPending = 1'b0;
  int          nBits = 0;
  logic [63:0] bitsVec = '0;
  int          framed = 0, gaps = 0, pads = 0, padBad = 0;
  int          finalCyc = -1000, startGap = 0, doneCount = 0;

  task automatic scoreboardCompare();
    int len;
    logic [3:0] a;
    logic [7:0] b;
    checkOutput("scoreboard has expected packet", expAddrQ.size() > 0, 1);
    if (expAddrQ.size() > 0) begin
      a   = expAddrQ.pop_front();
      len = expLenQ.pop_front();
      checkOutput("serial bit count", nBits, 4 + 8 * len);
      checkOutput("address bits", bitsVec[3:0], a);
      for (int i = 0; i < len; i++) begin
        b = expByteQ.pop_front();
        checkOutput("data byte", bitsVec[4 + 8 * i +: 8], b);
      end
    end
  endtask

  always @(negedge clock) begin
    mcyc++;
    if (!reset_n) begin
      inFrame    = 1'b0;
      eopPending = 1'b0;
    end else begin
      if (eopPending) begin
        eopPending = 1'b0;
        checkOutput("eop din", din, 0);
        checkOutput("eop valid_n", valid_n, 1);
        checkOutput("eop frame_n", frame_n, 1);
      end
      if (!inFrame && !frame_n) begin
        inFrame  = 1'b1;
        nBits    = 0;
        framed   = 0;
        gaps     = 0;
        pads     = 0;
        padBad   = 0;
        startGap = mcyc - finalCyc;
      end
      if (inFrame) begin
        framed++;
        if (!valid_n) begin
          if (nBits < 64) bitsVec[nBits] = din;
          nBits++;
        end else if (!frame_n) begin
          if (nBits == 4) pads++;
          else gaps++;
          if (din !== 1'b1) padBad++;
        end
        if (frame_n && !valid_n) begin
          inFrame    = 1'b0;
          finalCyc   = mcyc;
          eopPending = 1'b1;
          scoreboardCompare();
          doneCount++;
        end else if (frame_n) begin
          inFrame = 1'b0;
        end
      end
    end
  end

  typedef struct {
    logic [3:0] addr;
    int         nBytes;
    logic [7:0] data0;
    logic [7:0] data1;
    int         gapHold;
    int         expFramed;
    int         expGaps;
  } vec_t;

  vec_t vecs[5];

  task automatic sendByte(input logic [3:0] a, input logic [7:0] d, input logic l);
    int budget = 0;
    do begin
      @(negedge clock);
      budget++;
    end while (!txIf.s_ready && budget < 300);
    if (!txIf.s_ready) checkOutput("s_ready wait timeout", txIf.s_ready, 1);
    txIf.s_valid = 1'b1;
    txIf.s_addr  = a;
    txIf.s_data  = d;
    txIf.s_last  = l;
    @(posedge clock);
    #1;
    acceptCyc    = cyc;
    txIf.s_valid = 1'b0;
    txIf.s_last  = 1'b0;
  endtask

  task automatic expectPacket(input logic [3:0] a, input int n, input logic [7:0] d0, input logic [7:0] d1);
    router_pkt_t pkt;
    pkt.addr     = a;
    pkt.bytes    = new[n];
    pkt.bytes[0] = d0;
    if (n > 1) pkt.bytes[1] = d1;
    expAddrQ.push_back(pkt.addr);
    expLenQ.push_back(n);
    for (int i = 0; i < n; i++) expByteQ.push_back(pkt.bytes[i]);
  endtask

  task automatic waitPackets(input int target);
    int budget = 0;
    while (doneCount < target && budget < 400) begin
      @(negedge clock);
      budget++;
    end
    if (doneCount < target) checkOutput("packet completion timeout", doneCount, target);
    repeat (3) @(negedge clock);
  endtask

  task automatic applyStimulus(input vec_t v);
    int startDone;
    int e0;
    startDone = doneCount;
    expectPacket(v.addr, v.nBytes, v.data0, v.data1);
    sendByte(v.addr, v.data0, v.nBytes == 1);
    e0 = acceptCyc;
    if (v.nBytes > 1) begin
      if (v.gapHold > 0) begin
        while (cyc < e0 + 12 + PAD + v.gapHold - 1) begin
          @(posedge clock);
          #1;
        end
      end
      sendByte(v.addr, v.data1, 1'b1);
    end
    waitPackets(startDone + 1);
    checkOutput("framed cycles", framed, v.expFramed);
    checkOutput("gap cycles", gaps, v.expGaps);
    checkOutput("pad cycles", pads, PAD);
    checkOutput("pad/gap din not 1", padBad, 0);
    checkOutput("tx_busy after packet", tx_busy, 0);
    checkOutput("s_ready after packet", txIf.s_ready, 1);
  endtask

  task automatic pulseReset();
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    int startDone;
    txIf.s_valid = 1'b0;
    txIf.s_addr  = '0;
    txIf.s_data  = '0;
    txIf.s_last  = 1'b0;

    vecs[0] = '{addr: 4'h3, nBytes: 1, data0: 8'h33, data1: 8'h00, gapHold: 0, expFramed: 17, expGaps: 0};
    vecs[1] = '{addr: 4'h0, nBytes: 2, data0: 8'hA5, data1: 8'h0F, gapHold: 0, expFramed: 25, expGaps: 0};
    vecs[2] = '{addr: 4'h7, nBytes: 2, data0: 8'h01, data1: 8'h80, gapHold: 3, expFramed: 28, expGaps: 3};
    vecs[3] = '{addr: 4'hF, nBytes: 1, data0: 8'hFF, data1: 8'h00, gapHold: 0, expFramed: 17, expGaps: 0};
    vecs[4] = '{addr: 4'h9, nBytes: 2, data0: 8'h00, data1: 8'h5A, gapHold: 1, expFramed: 26, expGaps: 1};

    $display("[TB] reset checks");
    repeat (2) @(negedge clock);
    checkOutput("reset din", din, 0);
    checkOutput("reset frame_n", frame_n, 1);
    checkOutput("reset valid_n", valid_n, 1);
    checkOutput("reset s_ready", txIf.s_ready, 1);
    checkOutput("reset tx_busy", tx_busy, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("idle frame_n", frame_n, 1);
    checkOutput("idle valid_n", valid_n, 1);

    $display("[TB] vector table");
    for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

    $display("[TB] two queued packets");
    pulseReset();
    startDone = doneCount;
    expectPacket(4'h3, 1, 8'h33, 8'h00);
    expectPacket(4'h0, 1, 8'h77, 8'h00);
    sendByte(4'h3, 8'h33, 1'b1);
    sendByte(4'h0, 8'h77, 1'b1);
    @(negedge clock);
    checkOutput("s_ready while hold full", txIf.s_ready, 0);
    checkOutput("tx_busy while queued", tx_busy, 1);
    repeat (10) @(negedge clock);
    checkOutput("s_ready still low mid-packet", txIf.s_ready, 0);
    waitPackets(startDone + 2);
    checkOutput("cycles from final bit to next address", startGap, 3);
`ifdef ROUTER_TX_STATS_EN
    checkOutput("pkt_cnt", pkt_cnt, 2);
    checkOutput("byte_cnt", byte_cnt, 2);
`endif

    $display("[TB] reset in pad phase");
    sendByte(4'h5, 8'hC3, 1'b1);
    while (cyc < acceptCyc + 7) begin
      @(posedge clock);
      #1;
    end
    checkOutput("pad frame_n before reset", frame_n, 0);
    checkOutput("pad valid_n before reset", valid_n, 1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async reset din", din, 0);
    checkOutput("async reset frame_n", frame_n, 1);
    checkOutput("async reset valid_n", valid_n, 1);
    checkOutput("async reset s_ready", txIf.s_ready, 1);
    checkOutput("async reset tx_busy", tx_busy, 0);
    @(negedge clock);
    reset_n = 1'b1;
    applyStimulus(vecs[1]);

    checkOutput("scoreboard drained", expAddrQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time=%0t limit=%0t", $time, 2000000);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
